// File: rtl/filt_out_capture.sv
// Capture of the 1D filter output: drops warm-up samples, optionally decimates, buffers kept samples in a FWFT FIFO.
// Latency: a sample kept at edge N is presented on rd_valid/rd_data after edge N when the FIFO was empty.
// Backpressure: rd_ready stalls the read port; a kept sample arriving while full with no pop is dropped and sets sticky overflow.
// Optional FILT_CAP_DROPCNT_EN adds a saturating 16-bit drop_cnt output.

module filt_cap_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when a pop frees the slot on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && !flush && do_push) mem[wr_ptr] <= din;
    end
endmodule

module filt_out_capture #(
    parameter int DW     = 16,
    parameter int DEPTH  = 16,
    parameter int WARMUP = 8,
    parameter int DECIM  = 1,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] d,
    input  logic          in_en,
    input  logic          restart,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [LW-1:0] level,
    output logic          overflow,
`ifdef FILT_CAP_DROPCNT_EN
    output logic [15:0]   drop_cnt,
`endif
    output logic          warm
);
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int PCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [PCW-1:0] PLAST = PCW'(DECIM - 1);

    typedef enum logic {WARM, RUN} state_t;

    state_t         state;
    logic [WCW-1:0] wcnt;
    logic [PCW-1:0] phase;
    logic           keep;
    logic           pop;
    logic           full;
    logic           empty;
    logic           drop;

    assign keep     = (state == RUN) && in_en && (phase == '0);
    assign pop      = rd_valid && rd_ready;
    assign drop     = keep && full && !pop;
    assign rd_valid = !empty;
    assign warm     = (state == WARM);

    filt_cap_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (restart),
        .push    (keep),
        .pop     (rd_ready),
        .din     (d),
        .dout    (rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // Restart behaves as a local reset of everything but the clock.
    always_ff @(posedge clk) begin
        if (!reset_n || restart) begin
            state    <= (WARMUP > 0) ? WARM : RUN;
            wcnt     <= '0;
            phase    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                WARM: begin
                    if (in_en) begin
                        if (wcnt == WLAST) begin
                            state <= RUN;
                            wcnt  <= '0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    // Dropped samples still consume their decimation slot.
                    if (in_en) phase <= (phase == PLAST) ? '0 : phase + 1'b1;
                    if (drop)  overflow <= 1'b1;
                end
            endcase
        end
    end

`ifdef FILT_CAP_DROPCNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n || restart) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_filt_out_capture.sv
// Directed bench for filt_out_capture: default instance plus a WARMUP=0/DECIM=3 instance, scoreboard-checked reads.
module tb_filt_out_capture;
    logic        clk;
    logic        reset_n;
    logic        restart;
    logic [15:0] d, d2;
    logic        in_en, in_en2;
    logic        rd_ready, rd_ready2;
    logic        rd_valid, rd_valid2;
    logic [15:0] rd_data, rd_data2;
    logic [4:0]  level, level2;
    logic        overflow, overflow2;
    logic        warm, warm2;
`ifdef FILT_CAP_DROPCNT_EN
    logic [15:0] drop_cnt, drop_cnt2;
`endif

    logic [15:0] q[$];
    logic [15:0] q2[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_pop2 = 0;

    filt_out_capture #(.DW(16), .DEPTH(16), .WARMUP(8), .DECIM(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .d(d), .in_en(in_en), .restart(restart),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
        .overflow(overflow),
`ifdef FILT_CAP_DROPCNT_EN
        .drop_cnt(drop_cnt),
`endif
        .warm(warm)
    );

    filt_out_capture #(.DW(16), .DEPTH(16), .WARMUP(0), .DECIM(3)) u_dec (
        .clk(clk), .reset_n(reset_n), .d(d2), .in_en(in_en2), .restart(restart),
        .rd_ready(rd_ready2), .rd_valid(rd_valid2), .rd_data(rd_data2), .level(level2),
        .overflow(overflow2),
`ifdef FILT_CAP_DROPCNT_EN
        .drop_cnt(drop_cnt2),
`endif
        .warm(warm2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops are scored just before the edge that performs them, then one cycle advances.
    task automatic tick();
        if (reset_n && !restart) begin
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL rd_data: got %0h with empty scoreboard", rd_data);
                end else begin
                    chk("rd_data", {16'h0, rd_data}, {16'h0, q.pop_front()});
                end
            end
            if (rd_valid2 && rd_ready2) begin
                n_pop2++;
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL dec_rd_data: got %0h with empty scoreboard", rd_data2);
                end else begin
                    chk("dec_rd_data", {16'h0, rd_data2}, {16'h0, q2.pop_front()});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        reset_n = 1'b0; restart = 1'b0;
        d = '0; in_en = 1'b0; rd_ready = 1'b0;
        d2 = '0; in_en2 = 1'b0; rd_ready2 = 1'b0;
        tick(); tick();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_warm", warm, 1);
        chk("rst_dec_warm", warm2, 0);
`ifdef FILT_CAP_DROPCNT_EN
        chk("rst_drop_cnt", drop_cnt, 0);
`endif
        reset_n = 1'b1;

        // Decimation by 3 with in_en gaps that must not shift the phase
        rd_ready2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d2 = 16'(i); in_en2 = 1'b1;
            if (i % 3 == 0) q2.push_back(16'(i));
            tick();
            if (i == 4 || i == 7) begin
                in_en2 = 1'b0;
                tick();
            end
        end
        in_en2 = 1'b0;
        repeat (3) tick();
        chk("dec_pop_count", n_pop2, 4);
        chk("dec_sb_left", q2.size(), 0);

        // Warm-up discard
        rd_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            d = 16'(i); in_en = 1'b1;
            if (i > 8) q.push_back(16'(i));
            tick();
            if (i == 7) chk("warm_at7", warm, 1);
            if (i == 8) begin
                chk("warm_at8", warm, 0);
                chk("valid_at8", rd_valid, 0);
            end
            if (i == 9) begin
                chk("valid_at9", rd_valid, 1);
                chk("data_at9", rd_data, 9);
            end
        end
        in_en = 1'b0;
        repeat (3) tick();
        chk("warm_sb_left", q.size(), 0);
        chk("warm_level", level, 0);

        // Fill, then hold full with a concurrent push and pop each cycle
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            d = 16'(1000 + i); in_en = 1'b1; q.push_back(16'(1000 + i));
            tick();
        end
        chk("fill_level", level, 16);
        chk("fill_overflow", overflow, 0);
        rd_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            d = 16'(2000 + j); q.push_back(16'(2000 + j));
            tick();
            chk("fullpop_level", level, 16);
            chk("fullpop_overflow", overflow, 0);
        end
        in_en = 1'b0;
        repeat (20) tick();
        chk("fullpop_sb_left", q.size(), 0);
        chk("fullpop_drained", level, 0);

        // Overflow: 20 kept samples into a 16-deep FIFO with no reads
        rd_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            v = -10 + k;
            d = v[15:0]; in_en = 1'b1;
            if (k < 16) q.push_back(v[15:0]);
            tick();
            if (k == 15) begin
                chk("ovf_level16", level, 16);
                chk("ovf_before", overflow, 0);
            end
            if (k == 16) chk("ovf_at17", overflow, 1);
        end
        in_en = 1'b0;
        chk("ovf_level_end", level, 16);
`ifdef FILT_CAP_DROPCNT_EN
        chk("ovf_drop_cnt", drop_cnt, 4);
`endif
        rd_ready = 1'b1;
        repeat (16) tick();
        chk("ovf_sb_left", q.size(), 0);
        chk("ovf_sticky", overflow, 1);

        // Restart mid-stream with five entries buffered
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 16'(50 + i); in_en = 1'b1; q.push_back(16'(50 + i));
            tick();
        end
        in_en = 1'b0;
        chk("pre_restart_level", level, 5);
        restart = 1'b1; in_en = 1'b1; d = 16'd100; rd_ready = 1'b1;
        tick();
        restart = 1'b0; in_en = 1'b0;
        q.delete();
        chk("restart_level", level, 0);
        chk("restart_valid", rd_valid, 0);
        chk("restart_overflow", overflow, 0);
        chk("restart_warm", warm, 1);
`ifdef FILT_CAP_DROPCNT_EN
        chk("restart_drop_cnt", drop_cnt, 0);
`endif
        for (int i = 1; i <= 12; i++) begin
            d = 16'(100 + i); in_en = 1'b1;
            if (i > 8) q.push_back(16'(100 + i));
            tick();
            if (i == 7) chk("rwarm_at7", warm, 1);
            if (i == 8) begin
                chk("rwarm_at8", warm, 0);
                chk("rvalid_at8", rd_valid, 0);
            end
        end
        in_en = 1'b0;
        repeat (3) tick();
        chk("restart_sb_left", q.size(), 0);

        // Synchronous reset while holding data
        rd_ready = 1'b0;
        d = 16'd7; in_en = 1'b1; q.push_back(16'd7);
        tick();
        in_en = 1'b0;
        chk("prerst_valid", rd_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_not_yet_valid", rd_valid, 1);
        chk("rst_not_yet_level", level, 1);
        tick();
        q.delete();
        chk("syncrst_valid", rd_valid, 0);
        chk("syncrst_level", level, 0);
        chk("syncrst_data", rd_data, 0);
        chk("syncrst_warm", warm, 1);
        reset_n = 1'b1;

        // Signed extremes pass through bit-exact after a fresh warm-up
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 16'(i); in_en = 1'b1;
            tick();
        end
        d = 16'h8000; q.push_back(16'h8000);
        tick();
        d = 16'h7FFF; q.push_back(16'h7FFF);
        tick();
        in_en = 1'b0;
        repeat (3) tick();
        chk("extreme_sb_left", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/filt_out_capture.md
Name: filt_out_capture

Overview:
- Reader-side companion to the 1D filter. Takes the filter's free-running 16-bit signed output stream `q`, one sample per clock.
- Discards the pipeline warm-up samples and optionally decimates what remains.
- Buffers kept samples in a FIFO and presents them on a valid/ready read port, for a CPU/DMA drain or file-dump bench.
- Sits directly downstream of the filter, in the same clock domain.

Parameters:
- DW, 16, sample width (signed two's complement)
- DEPTH, 16, FIFO depth in samples; power of two, >= 2
- WARMUP, 8, accepted strobes discarded after reset/restart; 0 = none
- DECIM, 1, keep 1 of every DECIM post-warm-up samples; >= 1

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- d  in  DW  filter output sample (signed)
- in_en  in  1  d valid this cycle; tie high for one sample/clock
- restart  in  1  synchronous flush: empty FIFO, re-enter warm-up, clear overflow
- rd_ready  in  1  consumer accepts rd_data this cycle
- rd_valid  out  1  FIFO non-empty; rd_data valid
- rd_data  out  DW  FIFO head (first-word-fall-through)
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full
- warm  out  1  high while in WARM state

Behaviour:
- Decided: one clock; reset is synchronous and active-low (`clk`, `reset_n`).
- Reset (`reset_n` == 0 at a posedge):
  - state = WARM; warm-up count = 0; decimation phase = 0.
  - FIFO pointers = 0; rd_valid = 0; rd_data = 0; level = 0; overflow = 0.
  - warm = 1 when WARMUP > 0; otherwise state = RUN and warm = 0.
- State machine:
  - WARM: each cycle with in_en = 1 increments the warm-up count and discards d. When the count reaches WARMUP, go to RUN the next cycle. The strobe that completes WARMUP is itself discarded.
  - RUN: each in_en = 1 strobe is a candidate. Decimation phase counts 0..DECIM-1 and wraps. Only the phase-0 candidate is kept, so the first post-warm-up sample is kept.
  - restart = 1 at a posedge, from any state:
    - FIFO flushed; overflow cleared; counters cleared; state = WARM.
    - The in_en sample that cycle is discarded. A rd_ready that cycle has no effect.
    - restart has priority over every other event except reset.
- Write: a kept sample is written on the same posedge, provided the FIFO is not full or a pop happens that same cycle.
- Overflow:
  - A kept sample that arrives when full with no pop is dropped; overflow goes to 1 on that edge and holds until reset or restart.
  - Dropped samples still advance the decimation phase.
- Read:
  - Pop happens when rd_valid && rd_ready.
  - rd_data is the oldest entry and stays stable while rd_valid = 1 and rd_ready = 0.
  - rd_ready while empty has no effect.
- Latency: a sample written into an empty FIFO at edge N gives rd_valid = 1 with that data after edge N, one cycle.
- Simultaneous push and pop:
  - Full: accepted; level stays DEPTH; no overflow.
  - Empty: no pop; the push lands; level = 1.
  - Otherwise: level unchanged.
- Pointers wrap modulo DEPTH. Full/empty are decided by an extra pointer MSB or by level.
- Data passes through bit-exact; no arithmetic on samples.

Optional Feature:
- Macro: FILT_CAP_DROPCNT_EN.
- Defined:
  - Adds output `drop_cnt`, 16 bits: count of kept samples dropped on overflow.
  - Saturates at 16'hFFFF.
  - Cleared by reset and restart.
  - Increments on the same edge that sets overflow and on every later drop.
- Undefined: port and counter absent. overflow alone reports loss, and behaviour is otherwise identical.

Test Plan:
- Warm-up discard (WARMUP=8, DECIM=1, rd_ready=1): release reset, then drive d=1..20 with in_en=1 every cycle.
  - Samples read in order: 9..20.
  - warm falls after the 8th strobe.
  - First rd_valid one cycle after d=9 is written.
- Decimation (WARMUP=0, DECIM=3): drive d=0..11.
  - Read 0,3,6,9.
  - in_en gaps do not shift the phase; a gap only delays the next candidate.
- Overflow (DEPTH=16, rd_ready=0): push 20 kept samples -10..9.
  - level = 16.
  - overflow = 1 on the 17th kept sample.
  - Drain yields -10..5.
  - With FILT_CAP_DROPCNT_EN, drop_cnt = 4.
- Full with concurrent pop: hold FIFO full, then rd_ready=1 with a kept sample each cycle for 10 cycles.
  - overflow stays 0; level stays 16; output order is preserved.
- Restart mid-stream: level = 5, overflow = 1, pulse restart with in_en=1 and d=100.
  - Next cycle: level = 0, rd_valid = 0, overflow = 0, warm = 1.
  - d=100 is never read.
  - Warm-up repeats: 8 more strobes are discarded.
- Synchronous reset: assert reset_n=0 while rd_valid=1.
  - Outputs clear only at the next posedge, not before.
  - Signed extremes -32768 and 32767 then pass through unchanged.
